// File: rtl/llki_mock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : llki_mock_pkg
//  Description : Shared types, constants and the key-to-mask mapping function
//                for the mock LLKI key-lock stage.
//  Contents    : lock_state_t  - 2-bit lock FSM encoding
//                LLKI_WORD_W   - width of one key word (64)
//                LLKI_MAX_W    - upper bound for key and data widths
//                key_mask()    - cyclic key-difference to data-mask mapping
//  Revision    : 1.0 - initial release
// ============================================================================
package llki_mock_pkg;

   localparam int LLKI_WORD_W = 64;

   // Upper bound on KEY_W and NUM_CH*DATA_W handled by key_mask().
   localparam int LLKI_MAX_W = 1024;

   typedef enum logic [1:0] {
      LS_LOCKED   = 2'd0,
      LS_LOADING  = 2'd1,
      LS_UNLOCKED = 2'd2,
      LS_ERROR    = 2'd3
   } lock_state_t;

   // Mask bit j takes key-difference bit (j mod key_w): the difference
   // pattern is laid onto the data LSB-first and repeats every key_w bits.
   // Bits at or above width are returned as zero.
   function automatic logic [LLKI_MAX_W-1:0] key_mask(
      input logic [LLKI_MAX_W-1:0] diff,
      input int                    key_w,
      input int                    width
   );
      logic [LLKI_MAX_W-1:0] m;
      m = '0;
      if (key_w > 0) begin
         for (int j = 0; j < LLKI_MAX_W; j++) begin
            if (j < width) begin
               m[j] = diff[j % key_w];
            end
         end
      end
      return m;
   endfunction

endpackage : llki_mock_pkg
`default_nettype wire

// File: rtl/llki_mock_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : llki_mock_out_stage
//  Description : One-entry valid/ready register slice. Accepts a new word when
//                empty or when the held word leaves in the same cycle, giving
//                full throughput under continuous out_ready.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                in_valid/in_ready    - upstream handshake
//                in_data  [WIDTH]     - upstream payload
//                out_valid/out_ready  - downstream handshake
//                out_data [WIDTH]     - registered payload
//  Revision    : 1.0 - initial release
// ============================================================================
module llki_mock_out_stage
   import llki_mock_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         // Payload only moves with a real beat so an idle slot keeps its
         // last value on the bus.
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule : llki_mock_out_stage
`default_nettype wire

// File: rtl/llki_mock_key_lock.sv
`default_nettype none
// ============================================================================
//  Module      : llki_mock_key_lock
//  Description : Mock LLKI lock stage. Loads a multi-word key over a
//                valid/ready port, compares it with EXP_KEY and XOR-masks the
//                NUM_CH x DATA_W data stream with (EXP_KEY ^ loaded key), so
//                data passes clean only once the correct key is loaded.
//  Ports       : clk, rst_n                     - clock, async active-low reset
//                clear_key                      - pulse, zero loaded key
//                key_valid/key_ready/key_word/key_last - key word port
//                lock_state [2]                 - LOCKED/LOADING/UNLOCKED/ERROR
//                in_valid/in_ready/data_in      - data input port
//                out_valid/out_ready/data_out   - masked data output port
//  Revision    : 1.0 - initial release
// ============================================================================
module llki_mock_key_lock
   import llki_mock_pkg::*;
#(
   parameter int                         NUM_CH    = 4,
   parameter int                         DATA_W    = 16,
   parameter int                         KEY_WORDS = 2,
   parameter logic [64*KEY_WORDS-1:0]    EXP_KEY   = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_key,
   input  logic                       key_valid,
   output logic                       key_ready,
   input  logic [LLKI_WORD_W-1:0]     key_word,
   input  logic                       key_last,
   output logic [1:0]                 lock_state,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_CH*DATA_W-1:0]   data_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH*DATA_W-1:0]   data_out
);

   localparam int KEY_W = LLKI_WORD_W * KEY_WORDS;
   localparam int DW    = NUM_CH * DATA_W;
   localparam int CNT_W = $clog2(KEY_WORDS + 1);

   // Mask seen while no key is loaded: the plain EXP_KEY pattern.
   localparam logic [DW-1:0] RST_MASK =
      DW'(key_mask(LLKI_MAX_W'(EXP_KEY), KEY_W, DW));

   lock_state_t       state, state_nx;
   logic [KEY_W-1:0]  act_key, act_key_nx;
   logic [CNT_W-1:0]  wcnt, wcnt_nx;
   logic              len_err, len_err_nx;
   logic [DW-1:0]     mask, mask_nx;
   logic              mask_load;

   logic              key_acc;
   logic [CNT_W-1:0]  word_idx;
   logic              is_last_slot;
   logic [KEY_W-1:0]  key_new;

   logic              stage_in_valid;
   logic              stage_in_ready;

   // ------------------------------------------------------------------
   // Key port handshake: clear_key wins over any word in the same cycle.
   // ------------------------------------------------------------------
   assign key_ready  = !clear_key;
   assign key_acc    = key_valid && key_ready;
   assign lock_state = state;

   // ------------------------------------------------------------------
   // Lock FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LS_LOCKED;
         act_key <= '0;
         wcnt    <= '0;
         len_err <= 1'b0;
         mask    <= RST_MASK;
      end else begin
         state   <= state_nx;
         act_key <= act_key_nx;
         wcnt    <= wcnt_nx;
         len_err <= len_err_nx;
         if (mask_load) begin
            mask <= mask_nx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM: next state, key register and mask update
   // ------------------------------------------------------------------
   always_comb begin
      state_nx     = state;
      act_key_nx   = act_key;
      wcnt_nx      = wcnt;
      len_err_nx   = len_err;
      mask_load    = 1'b0;
      word_idx     = '0;
      key_new      = '0;
      is_last_slot = 1'b0;

      if (clear_key) begin
         state_nx   = LS_LOCKED;
         act_key_nx = '0;
         wcnt_nx    = '0;
         len_err_nx = 1'b0;
         mask_load  = 1'b1;
      end else if (state == LS_LOADING && len_err) begin
         // key_last arrived on the first word of a multi-word key: the word
         // was taken into LOADING, the length error is resolved one cycle on.
         state_nx   = LS_ERROR;
         wcnt_nx    = '0;
         len_err_nx = 1'b0;
         mask_load  = 1'b1;
      end else if (key_acc) begin
         // A word accepted outside LOADING starts a fresh key at slot 0.
         if (state == LS_LOADING) begin
            word_idx = wcnt;
            key_new  = act_key;
         end else begin
            word_idx = '0;
            key_new  = '0;
         end

         // Word n occupies the n-th 64-bit slot counted from the MS end.
         for (int w = 0; w < KEY_WORDS; w++) begin
            if (word_idx == CNT_W'(w)) begin
               key_new[KEY_W-1-w*LLKI_WORD_W -: LLKI_WORD_W] = key_word;
            end
         end

         act_key_nx   = key_new;
         is_last_slot = (word_idx == CNT_W'(KEY_WORDS - 1));

         if (state != LS_LOADING && KEY_WORDS > 1) begin
            state_nx   = LS_LOADING;
            wcnt_nx    = CNT_W'(1);
            len_err_nx = key_last;
         end else if (key_last || is_last_slot) begin
            if (key_last && is_last_slot && key_new == EXP_KEY) begin
               state_nx = LS_UNLOCKED;
            end else begin
               state_nx = LS_ERROR;
            end
            wcnt_nx   = '0;
            mask_load = 1'b1;
         end else begin
            state_nx = LS_LOADING;
            wcnt_nx  = word_idx + CNT_W'(1);
         end
      end

      mask_nx = DW'(key_mask(LLKI_MAX_W'(EXP_KEY ^ act_key_nx), KEY_W, DW));
   end

   // ------------------------------------------------------------------
   // Data path: data is held off while a key is being loaded so that no
   // beat is ever masked with a partially written key.
   // ------------------------------------------------------------------
   assign stage_in_valid = in_valid && (state != LS_LOADING);
   assign in_ready       = stage_in_ready && (state != LS_LOADING);

   llki_mock_out_stage #(
      .WIDTH (DW)
   ) u_out_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (stage_in_valid),
      .in_ready  (stage_in_ready),
      .in_data   (data_in ^ mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (data_out)
   );

endmodule : llki_mock_key_lock
`default_nettype wire

// File: tb/tb_llki_mock_key_lock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_llki_mock_key_lock
//  Description : Scoreboard bench for llki_mock_key_lock. Directed key loads
//                and data beats with hand-computed masked results; a monitor
//                pops expected beats whenever the DUT hands one downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_llki_mock_key_lock;

   localparam int          NUM_CH    = 4;
   localparam int          DATA_W    = 16;
   localparam int          KEY_WORDS = 2;
   localparam logic [127:0] EXP_KEY  = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [63:0]  W0       = 64'h0123456789ABCDEF;
   localparam logic [63:0]  W1       = 64'hFEDCBA9876543210;

   logic        clk;
   logic        rst_n;
   logic        clear_key;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_word;
   logic        key_last;
   logic [1:0]  lock_state;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;

   int          checks = 0;
   int          errors = 0;
   int          pushed = 0;
   int          popped = 0;
   logic [63:0] exp_q[$];
   logic        stream_done;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data  = '0;

   llki_mock_key_lock #(
      .NUM_CH    (NUM_CH),
      .DATA_W    (DATA_W),
      .KEY_WORDS (KEY_WORDS),
      .EXP_KEY   (EXP_KEY)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_key  (clear_key),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_word   (key_word),
      .key_last   (key_last),
      .lock_state (lock_state),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: handshakes complete on posedge, so the negedge before it sees
   // exactly the beat that is about to leave.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_data", data_out, prev_data);
            check("hold_valid", 64'(out_valid), 64'd1);
         end
         if (out_valid && !out_ready) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h, expected no beat", data_out);
            end else begin
               popped++;
               check("data_out", data_out, exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = data_out;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Presents one beat and holds it until accepted; in_valid stays high so
   // consecutive calls stream back-to-back. Caller drops in_valid.
   task automatic send_beat(input logic [63:0] d, input logic [63:0] expv);
      int n = 0;
      in_valid = 1'b1;
      data_in  = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got in_ready=0, expected 1 within 50 cycles");
      end else begin
         exp_q.push_back(expv);
         pushed++;
      end
      @(posedge clk);
      #1;
      if (n < 50) begin
         check("latency_valid", 64'(out_valid), 64'd1);
         check("latency_data", data_out, expv);
      end
   endtask

   task automatic send_key(input logic [63:0] w, input logic last);
      key_valid = 1'b1;
      key_word  = w;
      key_last  = last;
      @(negedge clk);
      check("key_ready", 64'(key_ready), 64'd1);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      key_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      clear_key   = 1'b0;
      key_valid   = 1'b0;
      key_word    = '0;
      key_last    = 1'b0;
      in_valid    = 1'b0;
      data_in     = '0;
      out_ready   = 1'b1;
      stream_done = 1'b0;

      // Reset values
      #12;
      check("rst_state", 64'(lock_state), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data_out", data_out, 64'd0);
      check("rst_key_ready", 64'(key_ready), 64'd1);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // LOCKED: data masked with the low EXP_KEY word
      send_beat(64'h0001_0002_0003_0004, 64'hFEDD_BA9A_7657_3214);
      drain();

      // Correct key: LOADING then UNLOCKED, data clean
      send_key(W0, 1'b0);
      check("load_state", 64'(lock_state), 64'd1);
      check("load_in_ready", 64'(in_ready), 64'd0);
      send_key(W1, 1'b1);
      check("unlock_state", 64'(lock_state), 64'd2);
      send_beat(64'hDEAD_BEEF_0000_FFFF, 64'hDEAD_BEEF_0000_FFFF);
      drain();

      // Wrong key, word 1 = 0: ERROR, low word of difference = W1
      send_key(W0, 1'b0);
      send_key(64'h0, 1'b1);
      check("err_state", 64'(lock_state), 64'd3);
      send_beat(64'h1111_2222_3333_4444, 64'hEFCD_98BA_4567_7654);
      drain();

      // Wrong key differing in low 8 bits only: mask = 0x00FF
      send_key(W0, 1'b0);
      send_key(W1 ^ 64'h00FF, 1'b1);
      check("err2_state", 64'(lock_state), 64'd3);
      send_beat(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DE0F);
      drain();

      // key_last on word 0: one LOADING cycle, then ERROR
      send_key(W0, 1'b1);
      check("early_state_loading", 64'(lock_state), 64'd1);
      check("early_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("early_state_err", 64'(lock_state), 64'd3);
      check("early_in_ready_high", 64'(in_ready), 64'd1);
      send_beat(64'h0, 64'hFEDC_BA98_7654_3210);
      drain();

      // Unlock, then clear_key together with key_valid
      send_key(W0, 1'b0);
      send_key(W1, 1'b1);
      check("unlock2_state", 64'(lock_state), 64'd2);
      clear_key = 1'b1;
      key_valid = 1'b1;
      key_word  = W0;
      @(negedge clk);
      check("clear_key_ready", 64'(key_ready), 64'd0);
      @(posedge clk);
      #1;
      clear_key = 1'b0;
      key_valid = 1'b0;
      check("clear_state", 64'(lock_state), 64'd0);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF);
      drain();

      // clear_key aborts a load
      send_key(W0, 1'b0);
      check("abort_loading", 64'(lock_state), 64'd1);
      clear_key = 1'b1;
      @(posedge clk);
      #1;
      clear_key = 1'b0;
      check("abort_state", 64'(lock_state), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);

      // Unlock and stream 8 beats under toggling out_ready
      send_key(W0, 1'b0);
      send_key(W1, 1'b1);
      check("unlock3_state", 64'(lock_state), 64'd2);
      out_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               send_beat(64'hA5A5_0000_0000_1000 + 64'(k), 64'hA5A5_0000_0000_1000 + 64'(k));
            end
            in_valid    = 1'b0;
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk);
               #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check("beat_count", 64'(popped), 64'(pushed));

      // Reset in the middle of a key load
      send_key(W0, 1'b0);
      check("midload_state", 64'(lock_state), 64'd1);
      rst_n = 1'b0;
      #2;
      check("midrst_state", 64'(lock_state), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("postrst_state", 64'(lock_state), 64'd0);
      send_beat(64'h0001_0002_0003_0004, 64'hFEDD_BA9A_7657_3214);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_llki_mock_key_lock
`default_nettype wire
